// File: rtl/uart_byte_tx_if.sv
// Byte handshake between the command/status logic (master) and the UART transmitter (slave).
interface uart_byte_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter: one byte per valid/ready handshake, LSB first on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bit(s).
module uart_byte_tx #(
   parameter int CLKS_PER_BIT = 2604,
   parameter int STOP_BITS    = 1
) (
   input  logic           clk_50M,
   input  logic           rst_n,
   uart_byte_tx_if.slave  host,
   output logic           tx,
   output logic           busy,
   output logic           tx_done
);

   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [2:0]    bit_idx, idx_nx;
   logic [7:0]    shreg, sh_nx;
   logic          tx_nx, done_nx;
   logic          bit_end, stop_last, ready, accept;
`ifdef UART_TX_PARITY_EN
   logic          par, par_nx;
`endif

   assign bit_end   = (cnt == CNT_MAX);
   assign stop_last = (state == STOP) && bit_end && (bit_idx == STOP_LAST);
   // Ready also during the final stop-bit cycle so a held tx_valid starts the
   // next frame on the same edge the current one ends: no idle gap.
   assign ready         = (state == IDLE) || stop_last;
   assign accept        = host.tx_valid && ready;
   assign host.tx_ready = ready;
   assign busy          = ~ready;

   always_comb begin
      state_nx = state;
      cnt_nx   = bit_end ? '0 : cnt + 1'b1;
      idx_nx   = bit_idx;
      sh_nx    = shreg;
      tx_nx    = tx;
      done_nx  = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_nx   = par;
`endif
      case (state)
         IDLE: begin
            cnt_nx = '0;
            tx_nx  = 1'b1;
         end
         START: if (bit_end) begin
            state_nx = DATA;
            tx_nx    = shreg[0];
            sh_nx    = {1'b0, shreg[7:1]};
            idx_nx   = 3'd0;
         end
         DATA: if (bit_end) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
               state_nx = PARITY;
               tx_nx    = par;
`else
               state_nx = STOP;
               tx_nx    = 1'b1;
               idx_nx   = 3'd0;
`endif
            end else begin
               idx_nx = bit_idx + 3'd1;
               tx_nx  = shreg[0];
               sh_nx  = {1'b0, shreg[7:1]};
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (bit_end) begin
            state_nx = STOP;
            tx_nx    = 1'b1;
            idx_nx   = 3'd0;
         end
`endif
         STOP: if (bit_end) begin
            // bit_idx counts stop bits here
            if (bit_idx == STOP_LAST) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end else begin
               idx_nx = bit_idx + 3'd1;
            end
         end
         default: begin
            state_nx = IDLE;
            tx_nx    = 1'b1;
         end
      endcase
      if (accept) begin
         state_nx = START;
         cnt_nx   = '0;
         idx_nx   = 3'd0;
         tx_nx    = 1'b0;
         sh_nx    = host.tx_data;
`ifdef UART_TX_PARITY_EN
         par_nx   = ^host.tx_data;
`endif
      end
   end

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= 3'd0;
         shreg   <= 8'h00;
         tx      <= 1'b1;
         tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par     <= 1'b0;
`endif
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         bit_idx <= idx_nx;
         shreg   <= sh_nx;
         tx      <= tx_nx;
         tx_done <= done_nx;
`ifdef UART_TX_PARITY_EN
         par     <= par_nx;
`endif
      end
   end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: two instances (16 clk/bit 1 stop, 8 clk/bit 2 stops) checked cycle by cycle against a frame model.
module tb_uart_byte_tx;

   logic clk_50M = 1'b0;
   logic rst_n   = 1'b0;
   int   checks  = 0;
   int   errors  = 0;

   always #5 clk_50M = ~clk_50M;

   uart_byte_tx_if if_a ();
   uart_byte_tx_if if_b ();
   logic tx_a, busy_a, done_a, tx_b, busy_b, done_b;

   uart_byte_tx #(.CLKS_PER_BIT(16), .STOP_BITS(1)) dut_a (
      .clk_50M(clk_50M), .rst_n(rst_n), .host(if_a.slave),
      .tx(tx_a), .busy(busy_a), .tx_done(done_a));

   uart_byte_tx #(.CLKS_PER_BIT(8), .STOP_BITS(2)) dut_b (
      .clk_50M(clk_50M), .rst_n(rst_n), .host(if_b.slave),
      .tx(tx_b), .busy(busy_b), .tx_done(done_b));

`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   function automatic int cpb(int w);  return (w != 0) ? 8 : 16; endfunction
   function automatic int nbits(int w); return 10 + ((w != 0) ? 2 : 1) - 1 + PAR; endfunction

   // Frame model: bit i of the serial frame for byte b.
   function automatic logic exp_bit(logic [7:0] b, int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return b[i-1];
      if (PAR == 1 && i == 9) return ^b;
      return 1'b1;
   endfunction

   function automatic logic o_tx(int w);    return (w != 0) ? tx_b : tx_a; endfunction
   function automatic logic o_rdy(int w);   return (w != 0) ? if_b.tx_ready : if_a.tx_ready; endfunction
   function automatic logic o_busy(int w);  return (w != 0) ? busy_b : busy_a; endfunction
   function automatic logic o_done(int w);  return (w != 0) ? done_b : done_a; endfunction

   task automatic chk(string tag, logic obs, logic expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
   endtask

   task automatic drv(int w, logic v, logic [7:0] d);
      if (w != 0) begin if_b.tx_valid = v; if_b.tx_data = d; end
      else        begin if_a.tx_valid = v; if_a.tx_data = d; end
   endtask

   task automatic chk_idle(int w, string tag);
      chk($sformatf("%s tx w%0d", tag, w),    o_tx(w),   1'b1);
      chk($sformatf("%s rdy w%0d", tag, w),   o_rdy(w),  1'b1);
      chk($sformatf("%s busy w%0d", tag, w),  o_busy(w), 1'b0);
      chk($sformatf("%s done w%0d", tag, w),  o_done(w), 1'b0);
   endtask

   // Call right after the acceptance edge. Scrambles tx_data mid-frame; if nv,
   // keeps tx_valid high and presents nb in time for a back-to-back acceptance.
   task automatic frame(int w, logic [7:0] b, bit prev_done, bit nv, logic [7:0] nb);
      int len;
      len = nbits(w) * cpb(w);
      #1 drv(w, nv, 8'($urandom));
      for (int k = 0; k < len; k++) begin
         @(negedge clk_50M);
         chk($sformatf("tx w%0d b%02h k%0d", w, b, k), o_tx(w), exp_bit(b, k / cpb(w)));
         chk($sformatf("rdy w%0d b%02h k%0d", w, b, k), o_rdy(w), k == len - 1);
         chk($sformatf("busy w%0d b%02h k%0d", w, b, k), o_busy(w), k != len - 1);
         chk($sformatf("done w%0d b%02h k%0d", w, b, k), o_done(w), (k == 0) && prev_done);
         if (nv && k == len - 1) drv(w, 1'b1, nb);
      end
      @(posedge clk_50M);
   endtask

   task automatic after_frame(int w);
      @(negedge clk_50M);
      chk($sformatf("end done w%0d", w), o_done(w), 1'b1);
      chk($sformatf("end tx w%0d", w),   o_tx(w),   1'b1);
      chk($sformatf("end rdy w%0d", w),  o_rdy(w),  1'b1);
      chk($sformatf("end busy w%0d", w), o_busy(w), 1'b0);
      @(negedge clk_50M);
      chk_idle(w, "post");
   endtask

   task automatic send(int w, logic [7:0] b);
      drv(w, 1'b1, b);
      @(posedge clk_50M);
      frame(w, b, 1'b0, 1'b0, 8'h00);
      after_frame(w);
   endtask

   initial begin
      logic [7:0] b0, b1;
      int         w;
      drv(0, 1'b0, 8'h00);
      drv(1, 1'b0, 8'h00);

      // reset state and idle line
      repeat (3) @(negedge clk_50M);
      chk_idle(0, "rst");
      chk_idle(1, "rst");
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_50M);
         chk_idle(0, "idle");
         chk_idle(1, "idle");
      end

      // single frames, including the 2-stop-bit instance with all-ones data
      send(0, 8'h4D);
      send(1, 8'hFF);

      // back-to-back 0x41 then 0x57 with tx_valid held
      drv(0, 1'b1, 8'h41);
      @(posedge clk_50M);
      frame(0, 8'h41, 1'b0, 1'b1, 8'h57);
      frame(0, 8'h57, 1'b1, 1'b0, 8'h00);
      after_frame(0);
      send(0, 8'h57);

      // reset during data bit 3 of 0x00 aborts the frame at once
      drv(0, 1'b1, 8'h00);
      @(posedge clk_50M);
      #1 drv(0, 1'b0, 8'hA5);
      repeat (70) @(posedge clk_50M);
      #2 chk("abort pre tx", tx_a, 1'b0);
      rst_n = 1'b0;
      #1 chk_idle(0, "abort");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_50M);
         chk_idle(0, "inrst");
      end
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_50M);
         chk_idle(0, "relse");
      end
      send(0, 8'h44);

      // random bytes, random instance, sometimes back-to-back
      for (int n = 0; n < 8; n++) begin
         w  = int'($urandom_range(0, 1));
         b0 = 8'($urandom);
         b1 = 8'($urandom);
         drv(w, 1'b1, b0);
         @(posedge clk_50M);
         if ($urandom_range(0, 1) == 1) begin
            frame(w, b0, 1'b0, 1'b1, b1);
            frame(w, b1, 1'b1, 1'b0, 8'h00);
         end else begin
            frame(w, b0, 1'b0, 1'b0, 8'h00);
         end
         after_frame(w);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
8N1 UART transmitter for the board-level serial link; the transmit-side counterpart of the WASD command receiver.
- Accepts one byte per valid/ready handshake and serializes it LSB-first on `tx`, with an internal bit-period counter.
- Sits between the command/status logic and the FPGA TX pin.
- Frees the top level from hard-coded constant transmission.

Parameters:
CLKS_PER_BIT, 2604, clk_50M cycles per serial bit (2604 -> ~19200 baud at 50 MHz); legal range 2..16383.
STOP_BITS, 1, number of stop bits per frame; legal values 1 or 2.

Ports:
clk_50M  input  1  system clock, 50 MHz; all logic is on the rising edge.
rst_n  input  1  asynchronous active-low reset.
tx_data  input  8  byte to transmit; sampled only on the acceptance edge.
tx_valid  input  1  tx_data holds a byte to send.
tx_ready  output  1  high when a byte can be accepted (state IDLE).
tx  output  1  serial line, registered, idle high.
busy  output  1  high whenever a frame is in progress (inverse of tx_ready).
tx_done  output  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; tx=1, tx_ready=1, busy=0, tx_done=0.
  - Bit counter, bit index and shift register are cleared.
  - Reset mid-frame aborts the frame immediately; tx returns high asynchronously and no tx_done is issued.
- Handshake:
  - A byte is accepted on the rising edge where tx_valid=1 and tx_ready=1.
  - tx_data is latched into the shift register on that edge; later changes to tx_data do not affect the frame.
  - tx_valid while tx_ready=0 is ignored; the source must hold it.
- State machine:
  - IDLE: tx=1. On acceptance go to START, with tx driven 0 from that same edge (zero latency).
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: output bits 0..7 in order, each held CLKS_PER_BIT cycles. The shift register shifts right once per bit. After bit 7 go to STOP.
  - STOP: hold tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final edge go to IDLE and pulse tx_done=1 for exactly one cycle.
- Frame timing:
  - The frame length is (10+STOP_BITS-1)*CLKS_PER_BIT cycles from the acceptance edge to the edge where tx_ready is 1 again.
- Bit timer:
  - Counter width is $clog2(CLKS_PER_BIT).
  - It counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary, and is reset to 0 on acceptance.
- Back-to-back frames:
  - If tx_valid is high in the cycle tx_ready returns high, the next byte is accepted on that edge.
  - In that case the start bit directly follows the stop bit, with no extra idle cycles.
  - tx_done and the new acceptance may occur on the same edge.
- Signal relationships: tx_ready and busy are mutually exclusive at all times.

Optional Feature:
UART_TX_PARITY_EN
- Defined: adds an even-parity bit after data bit 7, in a PARITY state lasting CLKS_PER_BIT cycles.
  - Parity is the XOR of the latched byte, computed at acceptance.
  - The frame grows by CLKS_PER_BIT cycles.
- Undefined: no PARITY state; DATA proceeds directly to STOP.

Test Plan:
1. Reset, then idle for 100 cycles -> tx=1, tx_ready=1, busy=0, tx_done=0 throughout.
2. CLKS_PER_BIT=16, send 0x4D -> tx sequence 0,1,0,1,1,0,0,1,0,1, each bit 16 cycles; tx_done pulses once; tx_ready high again 160 cycles after acceptance.
3. CLKS_PER_BIT=16, tx_valid held with 0x41 then 0x57 -> second start bit immediately follows the first stop bit; two tx_done pulses 160 cycles apart; tx_data changed mid-frame has no effect.
4. STOP_BITS=2, CLKS_PER_BIT=8, send 0xFF -> tx low for 8 cycles, then high for 80 cycles; tx_done at cycle 88.
5. Assert rst_n=0 during data bit 3 of 0x00 -> tx=1 immediately, no tx_done; after release, tx_ready=1 and a new 0x44 transmits correctly.
6. UART_TX_PARITY_EN defined, CLKS_PER_BIT=16, send 0x57 -> parity bit 1 after the data bits; frame 176 cycles. Sending 0x4D gives parity bit 0.
